// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC job driver.
package mac_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_FP16 = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StStream,
        StDrain,
        StRead,
        StResp
    } state_e;

endpackage

// File: rtl/mac_job_driver.sv
// Drives one MAC through cfg / stream / drain / read for a host job and returns the result.
// Optional stall timeout in STREAM is enabled by defining MAC_DRV_TIMEOUT_EN.
module mac_job_driver
    import mac_pkg::*;
#(
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned DRAIN_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_start,
    input  logic              job_mode,
    input  logic [LEN_W-1:0]  job_len,
    output logic              busy,
    output logic              job_err,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              mac_cfg,
    output logic              mac_mode,
    output logic              mac_enable,
    output logic              mac_valid,
    output logic              mac_read,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_error,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error
);

    localparam int unsigned DrainW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_error_q, res_error_d;
    logic                job_err_q, job_err_d;
    logic                beat;
    logic                timeout;

    // op_ready is constant 1 in STREAM, so op_valid alone marks an accepted beat.
    assign beat = (state_q == StStream) && op_valid;

`ifdef MAC_DRV_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] stall_q, stall_d;
    logic            stalling;

    assign stalling = (state_q == StStream) && !op_valid;
    assign timeout  = stalling && (stall_q == TmoW'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_d = '0;
        if (stalling) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic [31:0] timeout_cyc_unused;

    assign timeout            = 1'b0;
    assign timeout_cyc_unused = TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (job_start && (job_len != '0)) begin
                    state_d = StCfg;
                end
            end
            StCfg: state_d = StStream;
            StStream: begin
                if (beat && (cnt_q == LEN_W'(1))) begin
                    state_d = (DRAIN_CYC == 0) ? StRead : StDrain;
                end else if (timeout) begin
                    state_d = StResp;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StRead;
                end
            end
            StRead: state_d = StResp;
            StResp: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;
        job_err_d   = 1'b0;
        drain_d     = (state_q == StDrain) ? drain_q + 1'b1 : '0;

        if ((state_q == StIdle) && job_start) begin
            if (job_len == '0) begin
                job_err_d = 1'b1;
            end else begin
                mode_d = job_mode;
                cnt_d  = job_len;
            end
        end
        if (beat) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (state_q == StRead) begin
            res_data_d  = mac_out;
            res_error_d = mac_error;
        end
        // A timed-out job reports an error result without ever reading the MAC.
        if (timeout) begin
            job_err_d   = 1'b1;
            res_data_d  = '0;
            res_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_INT8;
            cnt_q       <= '0;
            drain_q     <= '0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
            job_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
            job_err_q   <= job_err_d;
        end
    end

    always_comb begin
        busy       = 1'b0;
        op_ready   = 1'b0;
        mac_cfg    = 1'b0;
        mac_enable = 1'b0;
        mac_valid  = 1'b0;
        mac_read   = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        res_valid  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StCfg: begin
                busy    = 1'b1;
                mac_cfg = 1'b1;
            end
            StStream: begin
                busy       = 1'b1;
                op_ready   = 1'b1;
                mac_enable = 1'b1;
                mac_valid  = op_valid;
                mac_a      = op_a;
                mac_b      = op_b;
            end
            StDrain: begin
                busy       = 1'b1;
                mac_enable = 1'b1;
            end
            StRead: begin
                busy       = 1'b1;
                mac_enable = 1'b1;
                mac_read   = 1'b1;
            end
            StResp: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign mac_mode  = mode_q;
    assign job_err   = job_err_q;
    assign res_data  = res_data_q;
    assign res_error = res_error_q;

endmodule

// File: tb/tb_mac_job_driver.sv
// Self-checking bench for mac_job_driver with a stub MAC and a job-level reference model.
module tb_mac_job_driver;
    import mac_pkg::*;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned DRAIN = 1;
    localparam int unsigned TMO   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_start, job_mode;
    logic [LEN_W-1:0]  job_len;
    logic              busy, job_err;
    logic              op_valid, op_ready;
    logic [DATA_W-1:0] op_a, op_b;
    logic              mac_cfg, mac_mode, mac_enable, mac_valid, mac_read;
    logic [DATA_W-1:0] mac_a, mac_b, mac_out;
    logic              mac_error;
    logic              res_valid, res_ready, res_error;
    logic [DATA_W-1:0] res_data;
    logic [57:0]       all_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign all_out = {busy, job_err, op_ready, mac_cfg, mac_mode, mac_enable, mac_valid,
                      mac_read, mac_a, mac_b, res_valid, res_data, res_error};

    mac_job_driver #(
        .LEN_W      (LEN_W),
        .DRAIN_CYC  (DRAIN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_start (job_start),
        .job_mode  (job_mode),
        .job_len   (job_len),
        .busy      (busy),
        .job_err   (job_err),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_cfg   (mac_cfg),
        .mac_mode  (mac_mode),
        .mac_enable(mac_enable),
        .mac_valid (mac_valid),
        .mac_read  (mac_read),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_out   (mac_out),
        .mac_error (mac_error),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_error (res_error)
    );

    // Drives the result handshake back to IDLE; no checking.
    task automatic accept_result();
        job_start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        op_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        job_start = 1'b1;
        job_mode  = 1'b1;
        job_len   = 8'd5;
        op_valid  = 1'b1;
        op_a      = 16'hffff;
        op_b      = 16'hffff;
        mac_out   = 16'h1234;
        mac_error = 1'b0;
        res_ready = 1'b0;
        #22;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        job_start = 1'b0;
        op_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b res_valid=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_len_zero();
        int errs = 0;
        int act  = 0;
        @(posedge clk);
        #1;
        job_start = 1'b1;
        job_len   = '0;
        job_mode  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'($urandom_range(0, 1));
            #1;
            if (job_err) errs++;
            if (busy | op_ready | mac_cfg | mac_enable | mac_valid | mac_read | res_valid) act++;
            @(posedge clk);
            #1;
            job_start = 1'b0;
        end
        op_valid = 1'b0;
        total++;
        if (errs != 1) begin
            bad++;
            $display("FAIL len0_job_err: got %0d pulse cycles want 1", errs);
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL len0_activity: got %0d active cycles want 0", act);
        end
    endtask

    // pat: 0 = op_valid always, 1 = toggling, 2 = random (stall runs capped).
    task automatic run_job(input logic mode, input int len, input int pat, input logic err,
                           input int hold, input logic [DATA_W-1:0] stub);
        int   k = 0, acc = 0, t_last = -1, resp_k = -1, run = 0;
        int   nvalid = 0, beat_bad = 0, proto = 0, cfg_cnt = 0, read_cnt = 0, read_k = -1;
        int   en_bad = 0, mode_bad = 0, err_cnt = 0, bp_bad = 0;
        logic offer, exp_stream;
        mac_out   = stub;
        mac_error = err;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b1;
        job_mode  = mode;
        job_len   = LEN_W'(len);
        op_valid  = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        job_mode  = ~mode;
        job_len   = LEN_W'($urandom);
        while (k < len * 6 + 40) begin
            exp_stream = (k >= 1) && (acc < len);
            if (!exp_stream) offer = 1'($urandom_range(0, 1));
            else if (pat == 0) offer = 1'b1;
            else if (pat == 1) offer = (k % 2 == 1);
            else offer = (run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            op_valid = offer;
            op_a     = DATA_W'($urandom);
            op_b     = DATA_W'($urandom);
            #1;
            if (job_err) err_cnt++;
            if (res_valid) begin
                resp_k = k;
                break;
            end
            if (mac_valid) nvalid++;
            if (mac_valid !== (offer && exp_stream)) beat_bad++;
            if (mac_valid && (mac_a !== op_a || mac_b !== op_b)) beat_bad++;
            if (!exp_stream && (mac_a !== '0 || mac_b !== '0)) beat_bad++;
            if (op_ready !== exp_stream) beat_bad++;
            if (mac_cfg) begin
                cfg_cnt++;
                if (k != 0) proto++;
            end
            if (mac_cfg && mac_enable) proto++;
            if (mac_read && mac_valid) proto++;
            if (busy !== 1'b1) proto++;
            if (mac_read) begin
                read_cnt++;
                read_k = k;
            end
            if (mac_enable !== (k >= 1)) en_bad++;
            if (mac_mode !== mode) mode_bad++;
            if (exp_stream) begin
                if (offer) begin
                    acc++;
                    run = 0;
                    if (acc == len) t_last = k;
                end else begin
                    run++;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (resp_k < 0) begin
            bad++;
            $display("FAIL res_valid_seen: got none within %0d cycles want one", k);
        end
        total++;
        if (resp_k != t_last + int'(DRAIN) + 2) begin
            bad++;
            $display("FAIL res_latency: got %0d want %0d", resp_k, t_last + int'(DRAIN) + 2);
        end
        if (pat == 0) begin
            total++;
            if (resp_k != 1 + len + int'(DRAIN) + 1) begin
                bad++;
                $display("FAIL best_latency: got %0d want %0d", resp_k, 1 + len + int'(DRAIN) + 1);
            end
        end
        total++;
        if (nvalid != len) begin
            bad++;
            $display("FAIL mac_valid_count: got %0d want %0d", nvalid, len);
        end
        total++;
        if (beat_bad != 0) begin
            bad++;
            $display("FAIL beat_passthrough: got %0d bad cycles want 0", beat_bad);
        end
        total++;
        if (proto != 0 || cfg_cnt != 1) begin
            bad++;
            $display("FAIL protocol: got %0d violations cfg=%0d want 0 cfg=1", proto, cfg_cnt);
        end
        total++;
        if (read_cnt != 1 || read_k != resp_k - 1) begin
            bad++;
            $display("FAIL mac_read: got count=%0d at=%0d want 1 at=%0d", read_cnt, read_k,
                     resp_k - 1);
        end
        total++;
        if (en_bad != 0 || mode_bad != 0) begin
            bad++;
            $display("FAIL enable_mode: got en_bad=%0d mode_bad=%0d want 0 0", en_bad, mode_bad);
        end
        total++;
        if (err_cnt != 0) begin
            bad++;
            $display("FAIL job_err_quiet: got %0d want 0", err_cnt);
        end
        total++;
        if (res_data !== stub || res_error !== err) begin
            bad++;
            $display("FAIL res_value: got %h/%b want %h/%b", res_data, res_error, stub, err);
        end
        for (int i = 0; i < hold; i++) begin
            job_start = 1'b1;
            job_len   = LEN_W'($urandom_range(1, 255));
            op_valid  = 1'b1;
            @(posedge clk);
            #2;
            if (!res_valid || res_data !== stub || res_error !== err || !busy || mac_cfg) bp_bad++;
        end
        if (hold > 0) begin
            total++;
            if (bp_bad != 0) begin
                bad++;
                $display("FAIL backpressure_hold: got %0d bad cycles want 0", bp_bad);
            end
        end
        accept_result();
        #1;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL res_accept: got res_valid=%b busy=%b want 0 0", res_valid, busy);
        end
        @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b0 || mac_cfg !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored: got busy=%b cfg=%b want 0 0", busy, mac_cfg);
        end
    endtask

    task automatic test_fp16_basic();
        run_job(MODE_FP16, 3, 0, 1'b0, 0, 16'h1234);
    endtask

    task automatic test_int8_toggle();
        run_job(MODE_INT8, 4, 1, 1'b0, 0, 16'h1234);
    endtask

    task automatic test_backpressure();
        run_job(MODE_FP16, 5, 2, 1'b0, 5, 16'h1234);
    endtask

    task automatic test_mac_error();
        run_job(MODE_INT8, 2, 0, 1'b1, 0, 16'h1234);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 5; j++) begin
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), 2,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), DATA_W'($urandom));
        end
    endtask

    task automatic test_reset_mid_stream();
        int act = 0;
        mac_out = 16'h1234;
        @(posedge clk);
        #1;
        job_start = 1'b1;
        job_mode  = 1'b1;
        job_len   = 8'd10;
        op_valid  = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        op_valid  = 1'b1;
        op_a      = 16'h5a5a;
        op_b      = 16'ha5a5;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (mac_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_stream: got mac_valid=%b want 1", mac_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", all_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2;
            if (busy | res_valid | mac_enable | mac_valid | mac_read) act++;
        end
        op_valid = 1'b0;
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL post_reset_idle: got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_stall();
        int errs = 0, reads = 0, found = 0, act_bad = 0;
        mac_out   = 16'h1234;
        mac_error = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b1;
        job_mode  = MODE_INT8;
        job_len   = 8'd2;
        op_valid  = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op_a     = 16'h0101;
        op_b     = 16'h0202;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
`ifdef MAC_DRV_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            #1;
            if (job_err) errs++;
            if (mac_read) reads++;
            if (res_valid) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (found != 1) begin
            bad++;
            $display("FAIL timeout_resp: got no res_valid want res_valid");
        end
        total++;
        if (errs != 1 || reads != 0) begin
            bad++;
            $display("FAIL timeout_flags: got job_err=%0d read=%0d want 1 0", errs, reads);
        end
        total++;
        if (res_error !== 1'b1 || res_data !== '0) begin
            bad++;
            $display("FAIL timeout_value: got %h/%b want 0000/1", res_data, res_error);
        end
        act_bad = 0;
`else
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (job_err) errs++;
            if (res_valid || !busy || !mac_enable || mac_read) act_bad++;
        end
        total++;
        if (errs != 0 || act_bad != 0) begin
            bad++;
            $display("FAIL stall_wait: got job_err=%0d bad=%0d want 0 0", errs, act_bad);
        end
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mac_read) reads++;
            if (res_valid) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (found != 1 || reads != 1 || res_data !== 16'h1234 || res_error !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume: got found=%0d read=%0d %h/%b want 1 1 1234/0", found,
                     reads, res_data, res_error);
        end
`endif
        accept_result();
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_fp16_basic();
        test_int8_toggle();
        test_backpressure();
        test_mac_error();
        test_random_jobs();
        test_stall();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_job_driver.md
Name: mac_job_driver

Overview:
- Initiator/driver side of the MAC control interface (cfg / enable / valid / read / mode, in_a / in_b, mac_out / error).
- Accepts a job descriptor (mode, length) from a host and streams operand pairs from a valid/ready source into the MAC.
- After the last pair it drains, pulses read, captures mac_out and error, and holds the result on a valid/ready result port.
- Sits between the tile scheduler and one MAC instance.

Parameters:
- LEN_W, 8, width of job_len (max job 2^LEN_W-1 pairs)
- DRAIN_CYC, 1, idle cycles (enable=1, valid=0, read=0) between last beat and read
- TIMEOUT_CYC, 255, max consecutive stall cycles in STREAM (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  job request pulse/level; accepted only in IDLE
- job_mode  in  1  1: fp16, 0: int8
- job_len  in  LEN_W  number of operand pairs
- busy  out  1  high in every state except IDLE
- job_err  out  1  one-cycle pulse: rejected job (len=0) or timeout
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted when op_valid & op_ready
- op_a  in  16  operand A
- op_b  in  16  operand B
- mac_cfg  out  1  to MAC cfg
- mac_mode  out  1  to MAC mode
- mac_enable  out  1  to MAC enable
- mac_valid  out  1  to MAC valid
- mac_read  out  1  to MAC read
- mac_a  out  16  to MAC in_a
- mac_b  out  16  to MAC in_b
- mac_out  in  16  from MAC result
- mac_error  in  1  from MAC error
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_data  out  16  captured mac_out
- res_error  out  1  captured mac_error, or timeout abort

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and result registers cleared. rst_n low at any point aborts the job immediately, with no result produced.
- FSM states: IDLE, CFG, STREAM, DRAIN, READ, RESP.
- IDLE:
  - job_start=1 and job_len!=0: latch mode and len, go to CFG.
  - job_start=1 and job_len==0: pulse job_err, stay in IDLE.
- CFG (exactly 1 cycle): mac_cfg=1, mac_enable=0, mac_mode=latched mode. Go to STREAM.
- mac_mode holds the latched mode from CFG until the next job.
- STREAM:
  - mac_enable=1; op_ready=1.
  - mac_valid = op_valid; mac_a/mac_b = op_a/op_b combinational pass-through.
  - mac_a/mac_b are 0 outside STREAM.
  - Each accepted beat decrements the remaining count.
  - On the beat that takes the count to 0: go to DRAIN on the next cycle.
  - op_valid low: mac_valid=0, mac_enable stays 1, no count change.
- DRAIN: mac_enable=1, mac_valid=0, op_ready=0 for DRAIN_CYC cycles, then go to READ.
- READ (exactly 1 cycle): mac_enable=1, mac_read=1, mac_valid=0. Register res_data<=mac_out and res_error<=mac_error. Go to RESP.
- RESP:
  - res_valid=1; res_data and res_error held stable.
  - res_ready=1: go to IDLE next cycle.
  - res_valid stays high until accepted; no timeout applies in RESP.
- Protocol invariants:
  - mac_cfg is never high together with mac_enable.
  - mac_read is never high together with mac_valid.
  - mac_enable is 0 in IDLE, CFG and RESP.
- Control outputs are Moore-decoded from the state register. Only mac_valid, mac_a and mac_b are combinational from the op stream.
- job_start during a non-IDLE state is ignored, with no error.
- Latency: best-case start-to-res_valid = 1 (CFG) + len (STREAM) + DRAIN_CYC + 1 (READ) cycles.

Optional Feature:
- MAC_DRV_TIMEOUT_EN defined:
  - A stall counter in STREAM resets on every accepted beat.
  - When the counter reaches TIMEOUT_CYC: pulse job_err, skip DRAIN and READ, go to RESP with res_data=0 and res_error=1.
- Not defined: no counter; STREAM waits indefinitely.

Decomposition:
- Shared package mac_pkg holds:
  - state enum;
  - mode constants MODE_INT8=1'b0, MODE_FP16=1'b1;
  - data width constant DATA_W=16.
- No sub-module needed. The optional timeout counter may be a small mac_stall_timer instance.

Test Plan (bench uses a stub MAC: mac_out=16'h1234, mac_error=0 unless stated):
- fp16 job, len=3, op_valid always 1:
  - mac_cfg=1 for 1 cycle with mac_mode=1, then 3 mac_valid beats;
  - 1 drain cycle, mac_read=1 for 1 cycle;
  - res_valid=1 with res_data=16'h1234, res_error=0, 6 cycles after start.
- int8 job, len=4, op_valid toggling 1/0:
  - exactly 4 mac_valid pulses, with mac_a/mac_b matching op_a/op_b on each;
  - mac_enable held 1 throughout STREAM and DRAIN;
  - mac_mode=0.
- job_len=0: job_err pulses 1 cycle; busy stays 0; no MAC activity.
- Backpressure: res_ready=0 for 5 cycles in RESP; res_valid and res_data stay stable; second job_start is ignored until res_ready=1.
- Error: stub mac_error=1 during READ gives res_error=1. Deassert rst_n mid-STREAM: all outputs 0 at once, state IDLE, no res_valid.
- With MAC_DRV_TIMEOUT_EN and TIMEOUT_CYC=8: len=2 with only 1 beat supplied gives job_err and res_valid with res_error=1, res_data=0, with mac_read never asserted.
